wb_commit_queue: RTL and testbench

Parametrised writeback/commit stage that generalises the single-entry WB register into a DEPTH-entry in-order commit queue between MEM and the register file/CSR file. Retires at most one instruction per cycle from the queue head, tolerates register-file write-port back-pressure, performs exception/ERTN commit with full queue flush, and exports per-slot hazard/forwarding information to ID.

---
 rtl/wb_commit_queue.sv | 202 ++++++++++++++++++++
 tb/tb_wb_commit_queue.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_queue.sv
// In-order writeback commit queue between MEM and the register/CSR files.
// Retires one entry per cycle from the head; exceptions and ERTN flush the whole queue.
module wb_commit_queue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned EX_WD = 14,
    parameter logic [6*EX_WD-1:0] ECODE_TABLE = {
        6'h09, 6'h0B, 6'h0C, 6'h0D, 6'h00, 6'h00, 6'h08,
        6'h08, 6'h04, 6'h07, 6'h02, 6'h01, 6'h03, 6'h3F
    },
    parameter int unsigned ADEM_IDX = 7
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  ms_to_ws_valid,
    output logic                  ws_allowin,
    input  logic [XLEN-1:0]       ms_pc,
    input  logic [XLEN-1:0]       ms_result,
    input  logic [XLEN-1:0]       ms_vaddr,
    input  logic [XLEN-1:0]       ms_csr_wmask,
    input  logic [XLEN-1:0]       ms_csr_wvalue,
    input  logic                  ms_gr_we,
    input  logic [4:0]            ms_dest,
    input  logic [1:0]            ms_csr_op,
    input  logic [13:0]           ms_csr_rnum,
    input  logic [EX_WD-1:0]      ms_ex,
    input  logic                  ms_ertn,
    input  logic [4:0]            ms_tlb_op,

    input  logic                  rf_ready,
    output logic                  rf_we,
    output logic [4:0]            rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,

    output logic                  ws_ex_to_csr,
    output logic                  ws_ertn_flush,
    output logic                  ws_ex,
    output logic [5:0]            ws_ecode,
    output logic [8:0]            ws_esubcode,
    output logic [XLEN-1:0]       ws_vaddr,

    output logic                  ws_csr_we,
    output logic [13:0]           ws_csr_rnum,
    output logic [XLEN-1:0]       ws_csr_wmask,
    output logic [XLEN-1:0]       ws_csr_wvalue,
    input  logic [XLEN-1:0]       ws_csr_rvalue,

    output logic [4:0]            ws_tlb_op,

    output logic [DEPTH-1:0]      ws_rel_we,
    output logic [5*DEPTH-1:0]    ws_rel_dest,
    output logic [XLEN*DEPTH-1:0] ws_rel_data,
    output logic [DEPTH-1:0]      ws_rel_nofwd,

    output logic [31:0]           debug_wb_pc,
    output logic [3:0]            debug_wb_rf_wen,
    output logic [4:0]            debug_wb_rf_wnum,
    output logic [31:0]           debug_wb_rf_wdata
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = (EX_WD > 1) ? $clog2(EX_WD) : 1;

    logic [XLEN-1:0]  pc_q     [DEPTH];
    logic [XLEN-1:0]  result_q [DEPTH];
    logic [XLEN-1:0]  vaddr_q  [DEPTH];
    logic [XLEN-1:0]  wmask_q  [DEPTH];
    logic [XLEN-1:0]  wvalue_q [DEPTH];
    logic             gr_we_q  [DEPTH];
    logic [4:0]       dest_q   [DEPTH];
    logic [1:0]       csr_op_q [DEPTH];
    logic [13:0]      rnum_q   [DEPTH];
    logic [EX_WD-1:0] ex_q     [DEPTH];
    logic             ertn_q   [DEPTH];
    logic [4:0]       tlb_op_q [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          not_empty;
    logic          head_exc;
    logic          head_ert;
    logic          normal_commit;
    logic          pop;
    logic          push;
    logic [SW-1:0] ex_sel;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign not_empty     = (count != '0);
    assign head_exc      = not_empty & (|ex_q[head]);
    assign head_ert      = not_empty & ertn_q[head] & ~head_exc;
    assign pop           = not_empty & (head_exc | head_ert | ~gr_we_q[head] | rf_ready);
    assign normal_commit = pop & ~head_exc & ~head_ert;

    assign ws_allowin    = (count != CW'(DEPTH));
    assign ws_ex_to_csr  = head_exc;
    assign ws_ertn_flush = head_ert;
    assign ws_ex         = head_exc | head_ert;
    assign push          = ms_to_ws_valid & ws_allowin & ~ws_ex;

    // Lowest set exception index wins.
    always_comb begin
        ex_sel = '0;
        for (int i = EX_WD - 1; i >= 0; i--) begin
            if (ex_q[head][i]) begin
                ex_sel = SW'(i);
            end
        end
    end

    assign ws_ecode    = head_exc ? ECODE_TABLE[int'(ex_sel)*6 +: 6] : 6'h00;
    assign ws_esubcode = {8'h00, head_exc & (ex_sel == SW'(ADEM_IDX))};

    assign rf_we         = normal_commit & gr_we_q[head];
    assign rf_waddr      = dest_q[head];
    assign rf_wdata      = csr_op_q[head][0] ? ws_csr_rvalue : result_q[head];
    assign ws_csr_we     = normal_commit & csr_op_q[head][1];
    assign ws_tlb_op     = normal_commit ? tlb_op_q[head] : 5'h00;
    assign ws_csr_rnum   = rnum_q[head];
    assign ws_csr_wmask  = wmask_q[head];
    assign ws_csr_wvalue = wvalue_q[head];
    assign ws_vaddr      = vaddr_q[head];

    // Slot i of the hazard bus is the i-th oldest entry, not physical slot i.
    always_comb begin
        logic [PW-1:0] slot;
        ws_rel_we    = '0;
        ws_rel_nofwd = '0;
        ws_rel_dest  = '0;
        ws_rel_data  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot = head + PW'(i);
            ws_rel_dest[5*i +: 5]       = dest_q[slot];
            ws_rel_data[XLEN*i +: XLEN] = result_q[slot];
            if (CW'(i) < count) begin
                ws_rel_we[i]    = gr_we_q[slot] & ~(|ex_q[slot]);
                ws_rel_nofwd[i] = csr_op_q[slot][0] | (tlb_op_q[slot] != 5'h00);
            end
        end
    end

    assign debug_wb_pc       = not_empty ? 32'(pc_q[head]) : 32'h0;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = 32'(rf_wdata);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_q[i]     <= '0;
                result_q[i] <= '0;
                vaddr_q[i]  <= '0;
                wmask_q[i]  <= '0;
                wvalue_q[i] <= '0;
                gr_we_q[i]  <= 1'b0;
                dest_q[i]   <= '0;
                csr_op_q[i] <= '0;
                rnum_q[i]   <= '0;
                ex_q[i]     <= '0;
                ertn_q[i]   <= 1'b0;
                tlb_op_q[i] <= '0;
            end
        end else begin
            if (push) begin
                pc_q[tail]     <= ms_pc;
                result_q[tail] <= ms_result;
                vaddr_q[tail]  <= ms_vaddr;
                wmask_q[tail]  <= ms_csr_wmask;
                wvalue_q[tail] <= ms_csr_wvalue;
                gr_we_q[tail]  <= ms_gr_we;
                dest_q[tail]   <= ms_dest;
                csr_op_q[tail] <= ms_csr_op;
                rnum_q[tail]   <= ms_csr_rnum;
                ex_q[tail]     <= ms_ex;
                ertn_q[tail]   <= ms_ertn;
                tlb_op_q[tail] <= ms_tlb_op;
            end
            if (ws_ex) begin
                count <= '0;
                head  <= tail;
            end else begin
                if (push) begin
                    tail <= ptr_inc(tail);
                end
                if (pop) begin
                    head <= ptr_inc(head);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_wb_commit_queue.sv
// Bench for wb_commit_queue: directed test-plan steps plus random traffic
// against a queue-based reference model.
module tb_wb_commit_queue;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;

    typedef struct {
        logic [31:0] pc, result, vaddr, wmask, wvalue;
        logic        gr_we;
        logic [4:0]  dest;
        logic [1:0]  csr_op;
        logic [13:0] rnum;
        logic [13:0] ex;
        logic        ertn;
        logic [4:0]  tlb_op;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    logic ms_to_ws_valid, ws_allowin;
    logic [31:0] ms_pc, ms_result, ms_vaddr, ms_csr_wmask, ms_csr_wvalue;
    logic ms_gr_we, ms_ertn;
    logic [4:0] ms_dest, ms_tlb_op;
    logic [1:0] ms_csr_op;
    logic [13:0] ms_csr_rnum, ms_ex;
    logic rf_ready, rf_we;
    logic [4:0] rf_waddr;
    logic [31:0] rf_wdata;
    logic ws_ex_to_csr, ws_ertn_flush, ws_ex;
    logic [5:0] ws_ecode;
    logic [8:0] ws_esubcode;
    logic [31:0] ws_vaddr;
    logic ws_csr_we;
    logic [13:0] ws_csr_rnum;
    logic [31:0] ws_csr_wmask, ws_csr_wvalue, ws_csr_rvalue;
    logic [4:0] ws_tlb_op;
    logic [DEPTH-1:0] ws_rel_we, ws_rel_nofwd;
    logic [5*DEPTH-1:0] ws_rel_dest;
    logic [XLEN*DEPTH-1:0] ws_rel_data;
    logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0] debug_wb_rf_wen;
    logic [4:0] debug_wb_rf_wnum;

    wb_commit_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_result(ms_result), .ms_vaddr(ms_vaddr),
        .ms_csr_wmask(ms_csr_wmask), .ms_csr_wvalue(ms_csr_wvalue),
        .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_csr_op(ms_csr_op),
        .ms_csr_rnum(ms_csr_rnum), .ms_ex(ms_ex), .ms_ertn(ms_ertn), .ms_tlb_op(ms_tlb_op),
        .rf_ready(rf_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .ws_ex_to_csr(ws_ex_to_csr), .ws_ertn_flush(ws_ertn_flush), .ws_ex(ws_ex),
        .ws_ecode(ws_ecode), .ws_esubcode(ws_esubcode), .ws_vaddr(ws_vaddr),
        .ws_csr_we(ws_csr_we), .ws_csr_rnum(ws_csr_rnum), .ws_csr_wmask(ws_csr_wmask),
        .ws_csr_wvalue(ws_csr_wvalue), .ws_csr_rvalue(ws_csr_rvalue),
        .ws_tlb_op(ws_tlb_op),
        .ws_rel_we(ws_rel_we), .ws_rel_dest(ws_rel_dest), .ws_rel_data(ws_rel_data),
        .ws_rel_nofwd(ws_rel_nofwd),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    ent_t q[$];
    ent_t cur;
    logic cur_v;
    logic [5:0] etab [14] = '{6'h3F, 6'h03, 6'h01, 6'h02, 6'h07, 6'h04, 6'h08,
                              6'h08, 6'h00, 6'h00, 6'h0D, 6'h0C, 6'h0B, 6'h09};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t rnd_normal(input logic gr_we);
        ent_t e;
        e.pc = $urandom; e.result = $urandom; e.vaddr = $urandom;
        e.wmask = $urandom; e.wvalue = $urandom;
        e.gr_we = gr_we; e.dest = 5'($urandom);
        e.csr_op = 2'b00; e.rnum = 14'($urandom);
        e.ex = '0; e.ertn = 1'b0; e.tlb_op = '0;
        return e;
    endfunction

    task automatic drive(input ent_t e, input logic v);
        cur = e; cur_v = v;
        ms_to_ws_valid = v;
        ms_pc = e.pc; ms_result = e.result; ms_vaddr = e.vaddr;
        ms_csr_wmask = e.wmask; ms_csr_wvalue = e.wvalue;
        ms_gr_we = e.gr_we; ms_dest = e.dest; ms_csr_op = e.csr_op;
        ms_csr_rnum = e.rnum; ms_ex = e.ex; ms_ertn = e.ertn; ms_tlb_op = e.tlb_op;
    endtask

    // Expected behaviour of the current cycle, derived from the model queue.
    task automatic settle_check();
        ent_t h;
        logic has, exc, ert, popx, normal, exp_we;
        int lo;
        #1;
        has = (q.size() != 0);
        if (has) h = q[0];
        else h = rnd_normal(1'b0);
        exc    = has && (h.ex != 0);
        ert    = has && h.ertn && !exc;
        popx   = has && (exc || ert || !h.gr_we || rf_ready);
        normal = popx && !exc && !ert;
        exp_we = normal && h.gr_we;
        chk("allowin", ws_allowin, q.size() < DEPTH);
        chk("rf_we", rf_we, exp_we);
        chk("dbg_wen", debug_wb_rf_wen, {4{exp_we}});
        if (exp_we) begin
            chk("rf_waddr", rf_waddr, h.dest);
            chk("rf_wdata", rf_wdata, h.csr_op[0] ? ws_csr_rvalue : h.result);
            chk("dbg_wdata", debug_wb_rf_wdata, h.csr_op[0] ? ws_csr_rvalue : h.result);
        end
        chk("ex_to_csr", ws_ex_to_csr, exc);
        chk("ertn_flush", ws_ertn_flush, ert);
        chk("ws_ex", ws_ex, exc || ert);
        if (exc) begin
            lo = 0;
            for (int k = 13; k >= 0; k--) if (h.ex[k]) lo = k;
            chk("ecode", ws_ecode, etab[lo]);
            chk("esubcode", ws_esubcode, (lo == 7) ? 9'd1 : 9'd0);
        end
        chk("csr_we", ws_csr_we, normal && h.csr_op[1]);
        chk("tlb_op", ws_tlb_op, normal ? h.tlb_op : 5'd0);
        chk("dbg_pc", debug_wb_pc, has ? h.pc : 32'd0);
        if (has) begin
            chk("csr_rnum", ws_csr_rnum, h.rnum);
            chk("csr_wmask", ws_csr_wmask, h.wmask);
            chk("csr_wvalue", ws_csr_wvalue, h.wvalue);
            chk("vaddr", ws_vaddr, h.vaddr);
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (i < q.size()) begin
                chk("rel_we", ws_rel_we[i], q[i].gr_we && q[i].ex == 0);
                chk("rel_nofwd", ws_rel_nofwd[i], q[i].csr_op[0] || q[i].tlb_op != 0);
                if (q[i].gr_we) begin
                    chk("rel_dest", ws_rel_dest[5*i +: 5], q[i].dest);
                    chk("rel_data", ws_rel_data[32*i +: 32], q[i].result);
                end
            end else begin
                chk("rel_we_empty", ws_rel_we[i], 1'b0);
                chk("rel_nofwd_empty", ws_rel_nofwd[i], 1'b0);
            end
        end
    endtask

    task automatic tick();
        logic has, flush, popx, pushx;
        @(posedge clk);
        has   = (q.size() != 0);
        flush = has && (q[0].ex != 0 || q[0].ertn);
        popx  = has && (flush || !q[0].gr_we || rf_ready);
        pushx = cur_v && (q.size() < DEPTH) && !flush;
        if (flush) q.delete();
        else begin
            if (popx) void'(q.pop_front());
            if (pushx) q.push_back(cur);
        end
        @(negedge clk);
    endtask

    initial begin
        ent_t e;
        logic r;
        reset = 1'b1;
        rf_ready = 1'b1;
        ws_csr_rvalue = '0;
        drive(rnd_normal(1'b0), 1'b0);
        #1;
        chk("reset_allowin", ws_allowin, 1'b1);
        chk("reset_rf_we", rf_we, 1'b0);
        chk("reset_dbg_pc", debug_wb_pc, 32'd0);
        chk("reset_rel_we", ws_rel_we, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        settle_check();
        tick();

        // Single push retires next cycle.
        e = rnd_normal(1'b1);
        e.pc = 32'h1C000000; e.dest = 5'd4; e.result = 32'h11;
        drive(e, 1'b1);
        settle_check(); tick();
        drive(rnd_normal(1'b0), 1'b0);
        settle_check();
        chk("tp1_wen", rf_we, 1'b1);
        chk("tp1_wnum", debug_wb_rf_wnum, 5'd4);
        chk("tp1_wdata", debug_wb_rf_wdata, 32'h11);
        chk("tp1_pc", debug_wb_pc, 32'h1C000000);
        tick();
        settle_check();
        chk("tp1_empty_pc", debug_wb_pc, 32'd0);

        // Back-pressure: fill, stall, then drain in order with wrap.
        rf_ready = 1'b0;
        drive(rnd_normal(1'b1), 1'b1); settle_check(); tick();
        drive(rnd_normal(1'b1), 1'b1); settle_check(); tick();
        drive(rnd_normal(1'b1), 1'b1); settle_check();
        chk("full_allowin", ws_allowin, 1'b0);
        chk("stall_rf_we", rf_we, 1'b0);
        tick();
        rf_ready = 1'b1;
        settle_check(); tick();
        settle_check(); tick();
        drive(rnd_normal(1'b0), 1'b0);
        repeat (3) begin settle_check(); tick(); end

        // SYS at head with push in the same cycle.
        e = rnd_normal(1'b1); e.ex = 14'(1 << 12);
        drive(e, 1'b1); settle_check(); tick();
        drive(rnd_normal(1'b1), 1'b1);
        settle_check();
        chk("sys_ex", ws_ex_to_csr, 1'b1);
        chk("sys_ecode", ws_ecode, 6'h0B);
        chk("sys_rf_we", rf_we, 1'b0);
        tick();
        drive(rnd_normal(1'b0), 1'b0);
        settle_check();
        chk("sys_flushed_pc", debug_wb_pc, 32'd0);
        tick();

        // Exception priority and ADEM subcode.
        e = rnd_normal(1'b1); e.ex = 14'h00C0;
        drive(e, 1'b1); settle_check(); tick();
        drive(rnd_normal(1'b0), 1'b0); settle_check();
        chk("adef_ecode", ws_ecode, 6'h08);
        chk("adef_esub", ws_esubcode, 9'd0);
        tick();
        e = rnd_normal(1'b1); e.ex = 14'h0080;
        drive(e, 1'b1); settle_check(); tick();
        drive(rnd_normal(1'b0), 1'b0); settle_check();
        chk("adem_esub", ws_esubcode, 9'd1);
        tick();
        e = rnd_normal(1'b1); e.ex = 14'h2000;
        drive(e, 1'b1); settle_check(); tick();
        drive(rnd_normal(1'b0), 1'b0); settle_check();
        chk("ale_ecode", ws_ecode, 6'h09);
        tick();

        // CSR read to GR, then CSR write pulse.
        e = rnd_normal(1'b1); e.csr_op = 2'b01; e.rnum = 14'h5;
        drive(e, 1'b1); settle_check(); tick();
        ws_csr_rvalue = 32'hABCD;
        e = rnd_normal(1'b0); e.csr_op = 2'b10; e.wmask = 32'hFFFFFFFF; e.wvalue = 32'h3;
        drive(e, 1'b1);
        settle_check();
        chk("csrrd_wdata", rf_wdata, 32'hABCD);
        chk("csrrd_nofwd", ws_rel_nofwd[0], 1'b1);
        tick();
        drive(rnd_normal(1'b0), 1'b0);
        settle_check();
        chk("csrwr_pulse", ws_csr_we, 1'b1);
        tick();
        settle_check();
        chk("csrwr_pulse_end", ws_csr_we, 1'b0);
        tick();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            e = rnd_normal(1'($urandom));
            e.csr_op = 2'($urandom);
            if ($urandom_range(0, 5) == 0) e.tlb_op = 5'($urandom);
            case ($urandom_range(0, 9))
                0: e.ex = 14'(1 << $urandom_range(0, 13));
                1: e.ex = 14'($urandom);
                default: e.ex = '0;
            endcase
            e.ertn = ($urandom_range(0, 11) == 0);
            r = ($urandom_range(0, 9) < 7);
            drive(e, r);
            rf_ready = ($urandom_range(0, 9) < 7);
            ws_csr_rvalue = $urandom;
            settle_check();
            tick();
        end

        // Asynchronous reset while full and stalled.
        rf_ready = 1'b0;
        ws_csr_rvalue = '0;
        drive(rnd_normal(1'b1), 1'b1); settle_check(); tick();
        drive(rnd_normal(1'b1), 1'b1); settle_check(); tick();
        drive(rnd_normal(1'b1), 1'b0); settle_check(); tick();
        settle_check();
        chk("pre_rst_full", ws_allowin, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("rst_allowin", ws_allowin, 1'b1);
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_dbg_pc", debug_wb_pc, 32'd0);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        rf_ready = 1'b1;
        settle_check();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
